axi_slave2core: RTL and testbench

AXI_SLAVE2CORE -- requirements
Module: axi_slave2core

---
 rtl/axi_slave2core_pkg.sv | 35 +++
 rtl/axi_slave2core_if.sv | 72 +++++++
 rtl/axi_slave2core_burst_addr_gen.sv | 43 ++++
 rtl/axi_slave2core.sv | 163 ++++++++++++++++
 tb/tb_axi_slave2core.sv | 387 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_slave2core_pkg.sv
// ============================================================================
// Module      : axi_slave2core_pkg
// Description : Shared types and constants for the AXI-slave to core bridge:
//               FSM state enum, AXI burst encodings and response codes.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axi_slave2core_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    RD_RESP = 3'd3,
    WR_DATA = 3'd4,
    WR_REQ  = 3'd5,
    WR_WAIT = 3'd6,
    WR_RESP = 3'd7
  } state_t;

  localparam logic [1:0] FIXED = 2'b00;
  localparam logic [1:0] INCR  = 2'b01;
  localparam logic [1:0] WRAP  = 2'b10;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  // Only 32-bit beats are native; anything else is performed but flagged.
  localparam logic [2:0] SIZE_WORD = 3'b010;

endpackage

`default_nettype wire

// File: rtl/axi_slave2core_if.sv
// ============================================================================
// Module      : axi_slave2core_if
// Description : AXI4 bus (32-bit data) seen by the bridge.
//               slave modport  : used by axi_slave2core
//               master modport : used by whoever drives the bus
// Ports       : AW, W, B, AR, R channels (valid/ready handshakes + payload)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface axi_slave2core_if #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 4
);
  logic                      aw_valid, aw_ready;
  logic [AXI_ID_WIDTH-1:0]   aw_id;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]                aw_len;
  logic [2:0]                aw_size;
  logic [1:0]                aw_burst;

  logic                      w_valid, w_ready;
  logic [31:0]               w_data;
  logic [3:0]                w_strb;
  logic                      w_last;

  logic                      b_valid, b_ready;
  logic [AXI_ID_WIDTH-1:0]   b_id;
  logic [1:0]                b_resp;

  logic                      ar_valid, ar_ready;
  logic [AXI_ID_WIDTH-1:0]   ar_id;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]                ar_len;
  logic [2:0]                ar_size;
  logic [1:0]                ar_burst;

  logic                      r_valid, r_ready;
  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [31:0]               r_data;
  logic [1:0]                r_resp;
  logic                      r_last;

  modport slave (
    input  aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst,
    output aw_ready,
    input  w_valid, w_data, w_strb, w_last,
    output w_ready,
    output b_valid, b_id, b_resp,
    input  b_ready,
    input  ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst,
    output ar_ready,
    output r_valid, r_id, r_data, r_resp, r_last,
    input  r_ready
  );

  modport master (
    output aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst,
    input  aw_ready,
    output w_valid, w_data, w_strb, w_last,
    input  w_ready,
    input  b_valid, b_id, b_resp,
    output b_ready,
    output ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst,
    input  ar_ready,
    input  r_valid, r_id, r_data, r_resp, r_last,
    output r_ready
  );

endinterface

`default_nettype wire

// File: rtl/axi_slave2core_burst_addr_gen.sv
// ============================================================================
// Module      : axi_burst_addr_gen
// Description : Combinational next-beat address for AXI FIXED/INCR/WRAP bursts
//               with 4-byte beats.
// Ports       : addr      - current beat address
//               burst     - AXI burst type
//               len       - AXI len (beats - 1)
//               next_addr - address of the following beat
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_burst_addr_gen
  import axi_slave2core_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32
) (
  input  logic [AXI_ADDR_WIDTH-1:0] addr,
  input  logic [1:0]                burst,
  input  logic [7:0]                len,
  output logic [AXI_ADDR_WIDTH-1:0] next_addr
);

  logic [AXI_ADDR_WIDTH-1:0] incr_addr;
  logic [AXI_ADDR_WIDTH-1:0] wrap_mask;

  assign incr_addr = addr + AXI_ADDR_WIDTH'(4);
  // For legal wrap lengths (1,3,7,15) the window is (len+1)*4 bytes, so the
  // in-window offset mask is simply {len, 2'b11}.
  assign wrap_mask = AXI_ADDR_WIDTH'({len, 2'b11});

  always_comb begin
    next_addr = incr_addr;
    case (burst)
      FIXED:   next_addr = addr;
      WRAP:    next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
      default: next_addr = incr_addr;  // INCR, and reserved 2'b11 treated as INCR
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/axi_slave2core.sv
// ============================================================================
// Module      : axi_slave2core
// Description : AXI4 slave to simple req/gnt/rvalid core-bus bridge. One AXI
//               transaction at a time, one core request outstanding.
// Ports       : clk, rst_n (async, active-low)
//               axi          - AXI slave side (axi_slave2core_if.slave)
//               data_req_o / data_addr_o / data_we_o / data_be_o /
//               data_wdata_o - core request outputs
//               data_gnt_i / data_rvalid_i / data_rdata_i - core responses
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_slave2core
  import axi_slave2core_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 4   // must match the connected interface
) (
  input  logic                      clk,
  input  logic                      rst_n,
  axi_slave2core_if.slave           axi,
  output logic                      data_req_o,
  output logic [AXI_ADDR_WIDTH-1:0] data_addr_o,
  output logic                      data_we_o,
  output logic [3:0]                data_be_o,
  output logic [31:0]               data_wdata_o,
  input  logic                      data_gnt_i,
  input  logic                      data_rvalid_i,
  input  logic [31:0]               data_rdata_i
);

  state_t                    state;
  logic                      prio_write;   // 1: write wins the next AR/AW tie
  logic                      ar_ready_q, aw_ready_q;
  logic [AXI_ID_WIDTH-1:0]   id_q;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, next_addr;
  logic [7:0]                len_q, cnt_q;
  logic [1:0]                burst_q;
  logic [31:0]               data_q;       // read data for R, or write data for core
  logic [3:0]                strb_q;
  logic                      err_q;
  logic                      last_beat;

  assign last_beat = (cnt_q == len_q);

  axi_burst_addr_gen #(.AXI_ADDR_WIDTH(AXI_ADDR_WIDTH)) u_addr_gen (
    .addr      (addr_q),
    .burst     (burst_q),
    .len       (len_q),
    .next_addr (next_addr)
  );

  // Address-channel readies are registered: IDLE spends one cycle deciding,
  // then raises exactly one ready for a single cycle. The master keeps valid
  // high until the handshake, so the latch in the following cycle is safe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      prio_write <= 1'b0;
      ar_ready_q <= 1'b0;
      aw_ready_q <= 1'b0;
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      burst_q    <= '0;
      data_q     <= '0;
      strb_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ar_ready_q) begin
            ar_ready_q <= 1'b0;
            if (axi.ar_valid) begin
              id_q       <= axi.ar_id;
              addr_q     <= axi.ar_addr;
              len_q      <= axi.ar_len;
              burst_q    <= axi.ar_burst;
              cnt_q      <= '0;
              err_q      <= (axi.ar_size != SIZE_WORD);
              prio_write <= 1'b1;
              state      <= RD_REQ;
            end
          end else if (aw_ready_q) begin
            aw_ready_q <= 1'b0;
            if (axi.aw_valid) begin
              id_q       <= axi.aw_id;
              addr_q     <= axi.aw_addr;
              len_q      <= axi.aw_len;
              burst_q    <= axi.aw_burst;
              cnt_q      <= '0;
              err_q      <= (axi.aw_size != SIZE_WORD);
              prio_write <= 1'b0;
              state      <= WR_DATA;
            end
          end else if (axi.ar_valid && (!axi.aw_valid || !prio_write)) begin
            ar_ready_q <= 1'b1;
          end else if (axi.aw_valid) begin
            aw_ready_q <= 1'b1;
          end
        end
        RD_REQ:  if (data_gnt_i) state <= RD_WAIT;
        RD_WAIT: if (data_rvalid_i) begin
          data_q <= data_rdata_i;
          state  <= RD_RESP;
        end
        RD_RESP: if (axi.r_ready) begin
          if (last_beat) begin
            state <= IDLE;
          end else begin
            addr_q <= next_addr;
            cnt_q  <= cnt_q + 8'd1;
            state  <= RD_REQ;
          end
        end
        WR_DATA: if (axi.w_valid) begin
          data_q <= axi.w_data;
          strb_q <= axi.w_strb;
          // The beat counter defines the burst end; w_last only flags errors.
          if (axi.w_last != last_beat) err_q <= 1'b1;
          state  <= WR_REQ;
        end
        WR_REQ:  if (data_gnt_i) state <= WR_WAIT;
        WR_WAIT: if (data_rvalid_i) begin
          if (last_beat) begin
            state <= WR_RESP;
          end else begin
            addr_q <= next_addr;
            cnt_q  <= cnt_q + 8'd1;
            state  <= WR_DATA;
          end
        end
        WR_RESP: if (axi.b_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // All handshake outputs decode from registers only.
  assign axi.ar_ready = ar_ready_q;
  assign axi.aw_ready = aw_ready_q;
  assign axi.w_ready  = (state == WR_DATA);
  assign axi.r_valid  = (state == RD_RESP);
  assign axi.r_id     = id_q;
  assign axi.r_data   = data_q;
  assign axi.r_resp   = err_q ? SLVERR : OKAY;
  assign axi.r_last   = (state == RD_RESP) && last_beat;
  assign axi.b_valid  = (state == WR_RESP);
  assign axi.b_id     = id_q;
  assign axi.b_resp   = err_q ? SLVERR : OKAY;

  assign data_req_o   = (state == RD_REQ) || (state == WR_REQ);
  assign data_we_o    = (state == WR_REQ);
  assign data_be_o    = (state == WR_REQ) ? strb_q :
                        (state == RD_REQ) ? 4'hF   : 4'h0;
  assign data_addr_o  = addr_q;
  assign data_wdata_o = data_q;

endmodule

`default_nettype wire

// File: tb/tb_axi_slave2core.sv
// ============================================================================
// Module      : tb_axi_slave2core
// Description : Self-checking bench for axi_slave2core. Expected core requests,
//               R beats and B responses are queued when stimulus is issued and
//               popped by independent monitors whenever the DUT presents them.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_axi_slave2core;
  import axi_slave2core_pkg::*;

  localparam int AW  = 32;
  localparam int IW  = 4;
  localparam int LIM = 600;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_slave2core_if #(.AXI_ADDR_WIDTH(AW), .AXI_ID_WIDTH(IW)) axi ();

  logic          data_req_o, data_we_o;
  logic [AW-1:0] data_addr_o;
  logic [3:0]    data_be_o;
  logic [31:0]   data_wdata_o;
  logic          data_gnt_i = 1'b0;
  logic          data_rvalid_i = 1'b0;
  logic [31:0]   data_rdata_i = 32'h0;

  axi_slave2core #(.AXI_ADDR_WIDTH(AW), .AXI_ID_WIDTH(IW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .axi           (axi),
    .data_req_o    (data_req_o),
    .data_addr_o   (data_addr_o),
    .data_we_o     (data_we_o),
    .data_be_o     (data_be_o),
    .data_wdata_o  (data_wdata_o),
    .data_gnt_i    (data_gnt_i),
    .data_rvalid_i (data_rvalid_i),
    .data_rdata_i  (data_rdata_i)
  );

  typedef struct packed {logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata;} core_t;
  typedef struct packed {logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last;} r_t;
  typedef struct packed {logic [3:0] id; logic [1:0] resp;} b_t;
  typedef struct packed {logic [31:0] data; logic [3:0] strb; logic last;} wbeat_t;

  core_t  core_q[$];
  r_t     r_q[$];
  b_t     b_q[$];
  wbeat_t w_beats[$];

  logic [31:0] mem [logic [31:0]];
  int n_checks = 0;
  int n_fail   = 0;
  int gnt_delay = -1;   // -1: random
  int rv_delay  = -1;
  int r_hold = 0, b_hold = 0;
  int grant_cnt = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  // Address of the next beat, from the AXI burst rules.
  function automatic logic [31:0] model_next(input logic [31:0] a, input logic [1:0] burst, input int len);
    int unsigned bytes, base;
    if (burst == FIXED) return a;
    if (burst == WRAP) begin
      bytes = (len + 1) * 4;
      base  = a - (a % bytes);
      return base + ((a - base + 4) % bytes);
    end
    return a + 32'd4;
  endfunction

  task automatic expect_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                             input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] a;
    a = addr;
    for (int b = 0; b <= len; b++) begin
      core_q.push_back(core_t'{1'b0, a, 4'hF, 32'h0});
      r_q.push_back(r_t'{id, mem_val(a), (size != 3'b010) ? SLVERR : OKAY, (b == len)});
      a = model_next(a, burst, len);
    end
  endtask

  task automatic expect_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                              input logic [2:0] size, input logic [1:0] burst,
                              input int bad, input int strb);
    logic [31:0] a;
    logic err;
    wbeat_t wb;
    a = addr;
    err = (size != 3'b010);
    for (int b = 0; b <= len; b++) begin
      wb.data = $urandom;
      wb.strb = (strb < 0) ? 4'($urandom) : 4'(strb);
      wb.last = (b == len) ^ (b == bad);
      if (wb.last != (b == len)) err = 1'b1;
      w_beats.push_back(wb);
      core_q.push_back(core_t'{1'b1, a, wb.strb, wb.data});
      a = model_next(a, burst, len);
    end
    b_q.push_back(b_t'{id, err ? SLVERR : OKAY});
  endtask

  task automatic drive_ar(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input logic [2:0] size, input logic [1:0] burst);
    int n;
    n = 0;
    axi.ar_valid = 1'b1; axi.ar_id = id; axi.ar_addr = addr;
    axi.ar_len = 8'(len); axi.ar_size = size; axi.ar_burst = burst;
    while (!axi.ar_ready && n < LIM) begin @(negedge clk); n++; end
    check("ar handshake within bound", 64'(n < LIM), 64'd1);
    @(negedge clk);
    axi.ar_valid = 1'b0;
  endtask

  task automatic drive_aw(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input logic [2:0] size, input logic [1:0] burst);
    int n;
    n = 0;
    axi.aw_valid = 1'b1; axi.aw_id = id; axi.aw_addr = addr;
    axi.aw_len = 8'(len); axi.aw_size = size; axi.aw_burst = burst;
    while (!axi.aw_ready && n < LIM) begin @(negedge clk); n++; end
    check("aw handshake within bound", 64'(n < LIM), 64'd1);
    @(negedge clk);
    axi.aw_valid = 1'b0;
  endtask

  task automatic drive_w();
    wbeat_t wb;
    int n;
    while (w_beats.size() > 0) begin
      wb = w_beats.pop_front();
      repeat ($urandom_range(0, 2)) @(negedge clk);
      axi.w_valid = 1'b1; axi.w_data = wb.data; axi.w_strb = wb.strb; axi.w_last = wb.last;
      n = 0;
      while (!axi.w_ready && n < LIM) begin @(negedge clk); n++; end
      check("w handshake within bound", 64'(n < LIM), 64'd1);
      @(negedge clk);
      axi.w_valid = 1'b0;
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((core_q.size() + r_q.size() + b_q.size()) != 0 && n < 6000) begin
      @(negedge clk); n++;
    end
    check("transaction completes within bound", 64'(n < 6000), 64'd1);
    core_q.delete(); r_q.delete(); b_q.delete(); w_beats.delete();
    @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " ar_ready"}, 64'(axi.ar_ready), 64'd0);
    check({tag, " aw_ready"}, 64'(axi.aw_ready), 64'd0);
    check({tag, " w_ready"},  64'(axi.w_ready),  64'd0);
    check({tag, " r_valid"},  64'(axi.r_valid),  64'd0);
    check({tag, " b_valid"},  64'(axi.b_valid),  64'd0);
    check({tag, " data_req"}, 64'(data_req_o),   64'd0);
    check({tag, " r_last"},   64'(axi.r_last),   64'd0);
    check({tag, " addr"},     64'(data_addr_o),  64'd0);
  endtask

  // Core-side responder and request monitor.
  initial begin
    int ph, cnt;
    logic [31:0] ga;
    logic gwe;
    core_t e;
    ph = 0; cnt = 0; ga = '0; gwe = 1'b0;
    forever begin
      @(negedge clk);
      data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = 32'h0;
      if (!rst_n) begin ph = 0; continue; end
      if (ph == 0 && data_req_o) begin
        cnt = (gnt_delay >= 0) ? gnt_delay : int'($urandom_range(0, 2));
        ph = 1;
      end
      if (ph == 1) begin
        if (cnt == 0) begin
          data_gnt_i = 1'b1;
          // Junk rvalid alongside gnt must be ignored by the DUT.
          if ($urandom_range(0, 1) == 1) begin data_rvalid_i = 1'b1; data_rdata_i = 32'hBADBAD00; end
          grant_cnt++;
          ga = data_addr_o; gwe = data_we_o;
          if (core_q.size() == 0) begin
            check("core request without expectation", 64'(data_addr_o), 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            e = core_q.pop_front();
            check("core we",   64'(data_we_o),   64'(e.we));
            check("core addr", 64'(data_addr_o), 64'(e.addr));
            check("core be",   64'(data_be_o),   64'(e.be));
            if (e.we) check("core wdata", 64'(data_wdata_o), 64'(e.wdata));
          end
          cnt = (rv_delay >= 0) ? rv_delay : int'($urandom_range(0, 2));
          ph = 2;
        end else cnt--;
      end else if (ph == 2) begin
        if (cnt == 0) begin
          data_rvalid_i = 1'b1;
          data_rdata_i  = gwe ? 32'($urandom) : mem_val(ga);
          ph = 0;
        end else cnt--;
      end
    end
  end

  // R/B ready generation and response monitors.
  initial begin
    r_t cur_r, prev_r, er;
    b_t cur_b, prev_b, eb;
    logic r_wait, b_wait;
    r_wait = 1'b0; b_wait = 1'b0; prev_r = '0; prev_b = '0;
    axi.r_ready = 1'b0; axi.b_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        r_wait = 1'b0; b_wait = 1'b0; axi.r_ready = 1'b0; axi.b_ready = 1'b0;
        continue;
      end
      if (axi.r_valid && r_hold > 0) begin axi.r_ready = 1'b0; r_hold--; end
      else axi.r_ready = ($urandom_range(0, 3) != 0);
      if (axi.b_valid && b_hold > 0) begin axi.b_ready = 1'b0; b_hold--; end
      else axi.b_ready = ($urandom_range(0, 3) != 0);

      if (axi.r_valid) begin
        cur_r = r_t'{axi.r_id, axi.r_data, axi.r_resp, axi.r_last};
        if (r_wait) check("R stable under backpressure", 64'(cur_r), 64'(prev_r));
        if (axi.r_ready) begin
          r_wait = 1'b0;
          if (r_q.size() == 0) check("R beat without expectation", 64'(cur_r), 64'hFFFF_FFFF_FFFF_FFFF);
          else begin er = r_q.pop_front(); check("R beat", 64'(cur_r), 64'(er)); end
        end else begin
          r_wait = 1'b1; prev_r = cur_r;
        end
      end
      if (axi.b_valid) begin
        cur_b = b_t'{axi.b_id, axi.b_resp};
        if (b_wait) check("B stable under backpressure", 64'(cur_b), 64'(prev_b));
        if (axi.b_ready) begin
          b_wait = 1'b0;
          if (b_q.size() == 0) check("B without expectation", 64'(cur_b), 64'hFFFF_FFFF_FFFF_FFFF);
          else begin eb = b_q.pop_front(); check("B response", 64'(cur_b), 64'(eb)); end
        end else begin
          b_wait = 1'b1; prev_b = cur_b;
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stimulus.
  initial begin
    logic [3:0]  id;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [1:0]  burst;
    int len, bad, g0, n;

    axi.aw_valid = 0; axi.aw_id = 0; axi.aw_addr = 0; axi.aw_len = 0; axi.aw_size = 0; axi.aw_burst = 0;
    axi.w_valid = 0; axi.w_data = 0; axi.w_strb = 0; axi.w_last = 0;
    axi.ar_valid = 0; axi.ar_id = 0; axi.ar_addr = 0; axi.ar_len = 0; axi.ar_size = 0; axi.ar_burst = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Single read, grant after 2 cycles.
    mem[32'h100] = 32'hDEADBEEF;
    gnt_delay = 2;
    expect_read(4'd3, 32'h100, 0, 3'b010, INCR);
    drive_ar(4'd3, 32'h100, 0, 3'b010, INCR);
    wait_done();
    gnt_delay = -1;

    // INCR write of four beats.
    expect_write(4'd1, 32'h200, 3, 3'b010, INCR, -1, 15);
    drive_aw(4'd1, 32'h200, 3, 3'b010, INCR);
    drive_w();
    wait_done();

    // WRAP read crossing the 16-byte window.
    expect_read(4'd7, 32'h10C, 3, 3'b010, WRAP);
    drive_ar(4'd7, 32'h10C, 3, 3'b010, WRAP);
    wait_done();

    // AR+AW together after a read: write first, 5 cycles of B/R backpressure.
    expect_write(4'd5, 32'h400, 1, 3'b010, INCR, -1, -1);
    expect_read(4'd6, 32'h500, 1, 3'b010, INCR);
    r_hold = 5; b_hold = 5;
    fork
      begin drive_aw(4'd5, 32'h400, 1, 3'b010, INCR); drive_w(); end
      drive_ar(4'd6, 32'h500, 1, 3'b010, INCR);
    join
    wait_done();

    // Early w_last on a two-beat write.
    expect_write(4'd2, 32'h600, 1, 3'b010, INCR, 0, -1);
    drive_aw(4'd2, 32'h600, 1, 3'b010, INCR);
    drive_w();
    wait_done();

    // Long INCR read wrapping the top of the address space.
    expect_read(4'd9, 32'hFFFF_FF00, 255, 3'b010, INCR);
    drive_ar(4'd9, 32'hFFFF_FF00, 255, 3'b010, INCR);
    wait_done();

    // Reset while waiting for read data: everything clears, no R follows.
    rv_delay = 30;
    g0 = grant_cnt;
    expect_read(4'd4, 32'h300, 0, 3'b010, INCR);
    drive_ar(4'd4, 32'h300, 0, 3'b010, INCR);
    n = 0;
    while (grant_cnt == g0 && n < LIM) begin @(negedge clk); n++; end
    check("read granted before reset", 64'(n < LIM), 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("mid-transaction reset");
    core_q.delete(); r_q.delete(); b_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rv_delay = -1;
    repeat (40) @(negedge clk);

    // After reset the priority is back to read.
    expect_read(4'd8, 32'h700, 0, 3'b010, INCR);
    expect_write(4'd10, 32'h800, 0, 3'b010, INCR, -1, -1);
    fork
      drive_ar(4'd8, 32'h700, 0, 3'b010, INCR);
      begin drive_aw(4'd10, 32'h800, 0, 3'b010, INCR); drive_w(); end
    join
    wait_done();

    // Randomized mix.
    for (int t = 0; t < 25; t++) begin
      id    = 4'($urandom);
      addr  = $urandom & 32'hFFFF_FFFC;
      size  = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : 3'b010;
      burst = 2'($urandom_range(0, 2));
      if (burst == WRAP) len = (4 << $urandom_range(0, 2)) - 1;
      else len = $urandom_range(0, 15);
      if (burst == WRAP && $urandom_range(0, 3) == 0) len = 1;
      if ($urandom_range(0, 1) == 1) begin
        expect_read(id, addr, len, size, burst);
        drive_ar(id, addr, len, size, burst);
      end else begin
        bad = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, len)) : -1;
        expect_write(id, addr, len, size, burst, bad, -1);
        drive_aw(id, addr, len, size, burst);
        drive_w();
      end
      wait_done();
    end

    repeat (10) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
